// File: rtl/rgmii_rx_frame_checker.sv
// Receive-side Ethernet frame checker: strips preamble/SFD, checks FCS, length and RGMII
// error status, forwards DA..payload with the FCS removed and keeps good/bad/drop statistics.
module rgmii_rx_frame_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk125,
    input  logic        rst_n,
    input  logic [7:0]  Data_In,
    input  logic        Val_In,
    input  logic        Err_In,
    input  logic        SoF_In,
    input  logic        EoF_In,
    output logic [7:0]  Data_Out,
    output logic        Val_Out,
    output logic        SoF_Out,
    output logic        EoF_Out,
    output logic        Good_Out,
    output logic        Bad_Out,
    output logic [2:0]  ErrCode_Out,
    output logic [15:0] GoodCnt,
    output logic [15:0] BadCnt,
    output logic [15:0] DropCnt
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [15:0] MIN_LEN16   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN16   = 16'(MAX_LEN);

    function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  preCnt_q, preCnt_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;
    logic        rgmiiErr_q, rgmiiErr_d;
    logic [7:0]  sr_q [4];
    logic [7:0]  sr_d [4];
    logic [2:0]  srCnt_q, srCnt_d;
    logic        firstPend_q, firstPend_d;
    logic [7:0]  dataOut_q, dataOut_d;
    logic        valOut_q, valOut_d;
    logic        sofOut_q, sofOut_d;
    logic        eofOut_q, eofOut_d;
    logic        good_q, good_d;
    logic        bad_q, bad_d;
    logic [2:0]  errCode_q, errCode_d;
    logic [15:0] goodCnt_q, goodCnt_d;
    logic [15:0] badCnt_q, badCnt_d;
    logic [15:0] dropCnt_q, dropCnt_d;

    logic [31:0] crcNext;
    logic [15:0] lenNext;
    logic        sofRule, enterPayload, dropByte;
    logic        crcErr, lenErr, rgmiiAny;

    assign crcNext = crcByte(crc_q, Data_In);
    assign lenNext = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            preCnt_q    <= 3'd0;
            crc_q       <= CRC_INIT;
            len_q       <= 16'd0;
            rgmiiErr_q  <= 1'b0;
            sr_q        <= '{default: '0};
            srCnt_q     <= 3'd0;
            firstPend_q <= 1'b0;
            dataOut_q   <= 8'd0;
            valOut_q    <= 1'b0;
            sofOut_q    <= 1'b0;
            eofOut_q    <= 1'b0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
            errCode_q   <= 3'd0;
            goodCnt_q   <= 16'd0;
            badCnt_q    <= 16'd0;
            dropCnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            preCnt_q    <= preCnt_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            rgmiiErr_q  <= rgmiiErr_d;
            sr_q        <= sr_d;
            srCnt_q     <= srCnt_d;
            firstPend_q <= firstPend_d;
            dataOut_q   <= dataOut_d;
            valOut_q    <= valOut_d;
            sofOut_q    <= sofOut_d;
            eofOut_q    <= eofOut_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            errCode_q   <= errCode_d;
            goodCnt_q   <= goodCnt_d;
            badCnt_q    <= badCnt_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        preCnt_d     = preCnt_q;
        crc_d        = crc_q;
        len_d        = len_q;
        rgmiiErr_d   = rgmiiErr_q;
        sr_d         = sr_q;
        srCnt_d      = srCnt_q;
        firstPend_d  = firstPend_q;
        dataOut_d    = dataOut_q;
        valOut_d     = 1'b0;
        sofOut_d     = 1'b0;
        eofOut_d     = 1'b0;
        good_d       = 1'b0;
        bad_d        = 1'b0;
        errCode_d    = 3'b000;
        goodCnt_d    = goodCnt_q;
        badCnt_d     = badCnt_q;
        dropCnt_d    = dropCnt_q;
        sofRule      = 1'b0;
        enterPayload = 1'b0;
        dropByte     = 1'b0;
        crcErr       = 1'b0;
        lenErr       = 1'b0;
        rgmiiAny     = 1'b0;

        if (Val_In) begin
            case (state_q)
                IDLE: sofRule = SoF_In;
                PREAMBLE: begin
                    if (SoF_In) begin
                        sofRule = 1'b1;
                    end else if (Err_In || EoF_In) begin
                        dropByte = 1'b1;
                    end else if (Data_In == PRE_BYTE) begin
                        if (preCnt_q == 3'd7) dropByte = 1'b1;
                        else                  preCnt_d = preCnt_q + 3'd1;
                    end else if (Data_In == SFD_BYTE) begin
                        enterPayload = 1'b1;
                    end else begin
                        dropByte = 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (SoF_In) begin
                        // Missing EoF: close the old frame with an abort marker, then restart
                        eofOut_d  = 1'b1;
                        bad_d     = 1'b1;
                        errCode_d = {1'b0, 1'b1, rgmiiErr_q};
                        badCnt_d  = badCnt_q + 16'd1;
                        srCnt_d   = 3'd0;
                        state_d   = IDLE;
                        sofRule   = 1'b1;
                    end else begin
                        crc_d      = crcNext;
                        len_d      = lenNext;
                        rgmiiAny   = rgmiiErr_q | Err_In;
                        rgmiiErr_d = rgmiiAny;
                        if (srCnt_q == 3'd4) begin
                            dataOut_d   = sr_q[0];
                            valOut_d    = 1'b1;
                            sofOut_d    = firstPend_q;
                            firstPend_d = 1'b0;
                            sr_d[0]     = sr_q[1];
                            sr_d[1]     = sr_q[2];
                            sr_d[2]     = sr_q[3];
                            sr_d[3]     = Data_In;
                        end else begin
                            sr_d[srCnt_q[1:0]] = Data_In;
                            srCnt_d            = srCnt_q + 3'd1;
                        end
                        if (EoF_In) begin
                            // A frame of 4 bytes or fewer never emitted anything: verdict rides an abort marker
                            crcErr    = (crcNext != CRC_RESIDUE);
                            lenErr    = (lenNext < MIN_LEN16) || (lenNext > MAX_LEN16) || (srCnt_q != 3'd4);
                            eofOut_d  = 1'b1;
                            errCode_d = {crcErr, lenErr, rgmiiAny};
                            if (crcErr || lenErr || rgmiiAny) begin
                                bad_d    = 1'b1;
                                badCnt_d = badCnt_q + 16'd1;
                            end else begin
                                good_d    = 1'b1;
                                goodCnt_d = goodCnt_q + 16'd1;
                            end
                            srCnt_d = 3'd0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (sofRule) begin
                if (EoF_In) begin
                    dropByte = 1'b1;
                end else if (Data_In == PRE_BYTE) begin
                    state_d  = PREAMBLE;
                    preCnt_d = 3'd1;
                end else if (Data_In == SFD_BYTE) begin
                    enterPayload = 1'b1;
                end else begin
                    dropByte = 1'b1;
                end
            end

            if (enterPayload) begin
                state_d     = PAYLOAD;
                crc_d       = CRC_INIT;
                len_d       = 16'd0;
                rgmiiErr_d  = 1'b0;
                srCnt_d     = 3'd0;
                firstPend_d = 1'b1;
            end

            if (dropByte) begin
                dropCnt_d = dropCnt_q + 16'd1;
                state_d   = IDLE;
            end
        end
    end

    assign Data_Out    = dataOut_q;
    assign Val_Out     = valOut_q;
    assign SoF_Out     = sofOut_q;
    assign EoF_Out     = eofOut_q;
    assign Good_Out    = good_q;
    assign Bad_Out     = bad_q;
    assign ErrCode_Out = errCode_q;
    assign GoodCnt     = goodCnt_q;
    assign BadCnt      = badCnt_q;
    assign DropCnt     = dropCnt_q;

endmodule

// File: tb/tb_rgmii_rx_frame_checker.sv
// Randomised bench for rgmii_rx_frame_checker: whole bursts are modelled as byte lists and the
// expected output events (data, strobes, verdict, arrival cycle) are derived per frame.
module tb_rgmii_rx_frame_checker;

    logic        clk125 = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  Data_In = 8'd0;
    logic        Val_In = 1'b0;
    logic        Err_In = 1'b0;
    logic        SoF_In = 1'b0;
    logic        EoF_In = 1'b0;
    logic [7:0]  Data_Out;
    logic        Val_Out, SoF_Out, EoF_Out, Good_Out, Bad_Out;
    logic [2:0]  ErrCode_Out;
    logic [15:0] GoodCnt, BadCnt, DropCnt;

    rgmii_rx_frame_checker #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
        .clk125(clk125), .rst_n(rst_n),
        .Data_In(Data_In), .Val_In(Val_In), .Err_In(Err_In), .SoF_In(SoF_In), .EoF_In(EoF_In),
        .Data_Out(Data_Out), .Val_Out(Val_Out), .SoF_Out(SoF_Out), .EoF_Out(EoF_Out),
        .Good_Out(Good_Out), .Bad_Out(Bad_Out), .ErrCode_Out(ErrCode_Out),
        .GoodCnt(GoodCnt), .BadCnt(BadCnt), .DropCnt(DropCnt)
    );

    always #4 clk125 = ~clk125;

    typedef struct packed {
        logic [7:0]  data;
        logic        val;
        logic        sof;
        logic        eof;
        logic        good;
        logic        bad;
        logic [2:0]  code;
        logic [31:0] stamp;
    } ev_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] cyc = 0;
    ev_t         gotQ[$];
    ev_t         expQ[$];
    logic [7:0]  pQ[$], bQ[$], mB[$], sB[$], cQ[$];
    bit          eQ[$], mE[$], sE[$];
    logic [31:0] dQ[$], mD[$], sD[$];
    logic [15:0] expGood = 0, expBad = 0, expDrop = 0;

    always @(posedge clk125) cyc <= cyc + 1;

    // Every cycle with any output strobe becomes one observed event
    always @(negedge clk125) begin
        ev_t ev;
        if (Val_Out || EoF_Out || Good_Out || Bad_Out) begin
            ev.data  = Val_Out ? Data_Out : 8'h00;
            ev.val   = Val_Out;
            ev.sof   = SoF_Out;
            ev.eof   = EoF_Out;
            ev.good  = Good_Out;
            ev.bad   = Bad_Out;
            ev.code  = ErrCode_Out;
            ev.stamp = cyc;
            gotQ.push_back(ev);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, cQ[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic makeFrame(input int nData);
        logic [31:0] f;
        pQ.delete();
        for (int i = 0; i < nData; i++) pQ.push_back(8'($urandom));
        cQ = pQ;
        f = crc32(nData);
        pQ.push_back(f[7:0]);
        pQ.push_back(f[15:8]);
        pQ.push_back(f[23:16]);
        pQ.push_back(f[31:24]);
    endtask

    task automatic buildBurst(input int nPre);
        bQ.delete();
        repeat (nPre) bQ.push_back(8'h55);
        bQ.push_back(8'hD5);
        foreach (pQ[i]) bQ.push_back(pQ[i]);
    endtask

    task automatic idleCycle();
        Data_In = 8'($urandom);
        Val_In  = 1'b0;
        SoF_In  = 1'($urandom);
        EoF_In  = 1'($urandom);
        Err_In  = 1'($urandom);
        @(posedge clk125);
        #1;
    endtask

    task automatic quiet();
        Val_In = 1'b0;
        SoF_In = 1'b0;
        EoF_In = 1'b0;
        Err_In = 1'b0;
    endtask

    task automatic settle();
        repeat (8) idleCycle();
        quiet();
    endtask

    // gapMode: 0 back-to-back, 1 one byte in three, 2 random gaps of 0..2 cycles
    task automatic driveBurst(input int gapMode, input int errIdx, input bit withEof);
        int ng;
        dQ.delete();
        eQ.delete();
        for (int i = 0; i < bQ.size(); i++) begin
            ng = (gapMode == 0) ? 0 : (gapMode == 1) ? 2 : int'($urandom_range(0, 2));
            repeat (ng) idleCycle();
            Data_In = bQ[i];
            Val_In  = 1'b1;
            SoF_In  = (i == 0);
            EoF_In  = withEof && (i == bQ.size() - 1);
            Err_In  = (i == errIdx);
            dQ.push_back(cyc);
            eQ.push_back(i == errIdx);
            @(posedge clk125);
            #1;
        end
        quiet();
    endtask

    task automatic useBurst();
        mB = bQ;
        mE = eQ;
        mD = dQ;
    endtask

    // endMode: 0 ended by EoF, 1 cut short by a new SoF at abortStamp, 2 cut short by reset
    task automatic modelBurst(input int endMode, input logic [31:0] abortStamp);
        int k, s, n, e;
        logic crcE, lenE, rgm;
        logic [2:0] code;
        logic [31:0] fcs;
        ev_t ev;
        k = 0;
        while (k < mB.size() && mB[k] == 8'h55) k++;
        rgm = 1'b0;
        for (int j = 1; j <= k && j < mB.size(); j++) rgm |= mE[j];
        if (k > 7 || k >= mB.size() || mB[k] != 8'hD5 || rgm || (k == mB.size() - 1 && endMode == 0)) begin
            expDrop++;
            return;
        end
        s = k + 1;
        n = mB.size() - s;
        rgm = 1'b0;
        for (int j = s; j < mB.size(); j++) rgm |= mE[j];
        e = (n > 4) ? n - 4 : 0;
        code = 3'b000;
        if (endMode == 0) begin
            cQ.delete();
            for (int j = 0; j < n - 4; j++) cQ.push_back(mB[s + j]);
            fcs  = {mB[s + n - 1], mB[s + n - 2], mB[s + n - 3], mB[s + n - 4]};
            crcE = (crc32(n - 4) != fcs);
            lenE = (n <= 4) || (n < 64) || (n > 1522);
            code = {crcE, lenE, rgm};
            if (code == 3'b000) expGood++;
            else                expBad++;
        end
        for (int j = 0; j < e; j++) begin
            ev       = '0;
            ev.data  = mB[s + j];
            ev.val   = 1'b1;
            ev.sof   = (j == 0);
            ev.stamp = mD[s + j + 4] + 1;
            if (endMode == 0 && j == e - 1) begin
                ev.eof  = 1'b1;
                ev.good = (code == 3'b000);
                ev.bad  = (code != 3'b000);
                ev.code = code;
            end
            expQ.push_back(ev);
        end
        if ((endMode == 0 && e == 0) || endMode == 1) begin
            ev       = '0;
            ev.eof   = 1'b1;
            ev.bad   = 1'b1;
            ev.code  = (endMode == 1) ? {1'b0, 1'b1, rgm} : code;
            ev.stamp = (endMode == 1) ? abortStamp : mD[mD.size() - 1] + 1;
            expQ.push_back(ev);
            if (endMode == 1) expBad++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({Data_Out, Val_Out, SoF_Out, EoF_Out, Good_Out, Bad_Out, ErrCode_Out} !== 17'd0) begin
            failures++;
            $display("[TB] FAIL reset_async_outputs got=%h exp=0", {Data_Out, Val_Out, SoF_Out, EoF_Out, Good_Out, Bad_Out, ErrCode_Out});
        end
        repeat (3) @(posedge clk125);
        #1;
        checks++;
        if ({GoodCnt, BadCnt, DropCnt} !== 48'd0) begin
            failures++;
            $display("[TB] FAIL reset_counters got=%h exp=0", {GoodCnt, BadCnt, DropCnt});
        end
        @(negedge clk125);
        rst_n = 1'b1;
        @(posedge clk125);
        #1;
        settle();
        checks++;
        if (gotQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_idle_noise got=%0d events exp=0", gotQ.size());
        end
        gotQ.delete();
    endtask

    task automatic test_good_frame();
        makeFrame(60);
        buildBurst(7);
        driveBurst(0, -1, 1);
        useBurst();
        modelBurst(0, 0);
        settle();
        checks++;
        if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL good_frame_events got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL good_frame_ev%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++;
        if ({GoodCnt, BadCnt, DropCnt} !== {expGood, expBad, expDrop}) begin failures++; $display("[TB] FAIL good_frame_counters got=%h exp=%h", {GoodCnt, BadCnt, DropCnt}, {expGood, expBad, expDrop}); end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_crc_error();
        makeFrame(60);
        pQ[17] = pQ[17] ^ 8'h08;
        buildBurst(7);
        driveBurst(0, -1, 1);
        useBurst();
        modelBurst(0, 0);
        settle();
        checks++;
        if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL crc_error_events got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL crc_error_ev%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++;
        if ({GoodCnt, BadCnt, DropCnt} !== {expGood, expBad, expDrop}) begin failures++; $display("[TB] FAIL crc_error_counters got=%h exp=%h", {GoodCnt, BadCnt, DropCnt}, {expGood, expBad, expDrop}); end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_rgmii_error_sparse();
        makeFrame(60);
        buildBurst(7);
        driveBurst(1, 8 + 19, 1);
        useBurst();
        modelBurst(0, 0);
        settle();
        checks++;
        if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL rgmii_err_events got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL rgmii_err_ev%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++;
        if ({GoodCnt, BadCnt, DropCnt} !== {expGood, expBad, expDrop}) begin failures++; $display("[TB] FAIL rgmii_err_counters got=%h exp=%h", {GoodCnt, BadCnt, DropCnt}, {expGood, expBad, expDrop}); end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_preamble_drop();
        bQ = '{8'h55, 8'h55, 8'h55, 8'h12};
        driveBurst(2, -1, 0);
        useBurst();
        modelBurst(0, 0);
        makeFrame(60);
        buildBurst(7);
        driveBurst(2, -1, 1);
        useBurst();
        modelBurst(0, 0);
        settle();
        checks++;
        if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL preamble_drop_events got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL preamble_drop_ev%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++;
        if ({GoodCnt, BadCnt, DropCnt} !== {expGood, expBad, expDrop}) begin failures++; $display("[TB] FAIL preamble_drop_counters got=%h exp=%h", {GoodCnt, BadCnt, DropCnt}, {expGood, expBad, expDrop}); end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_abort_and_oversize();
        makeFrame(26);
        buildBurst(7);
        driveBurst(2, -1, 0);
        sB = bQ; sE = eQ; sD = dQ;
        makeFrame(60);
        buildBurst(7);
        driveBurst(2, -1, 1);
        mB = sB; mE = sE; mD = sD;
        modelBurst(1, dQ[0] + 1);
        useBurst();
        modelBurst(0, 0);
        makeFrame(1526);
        buildBurst(7);
        driveBurst(0, -1, 1);
        useBurst();
        modelBurst(0, 0);
        settle();
        checks++;
        if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL abort_events got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL abort_ev%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++;
        if ({GoodCnt, BadCnt, DropCnt} !== {expGood, expBad, expDrop}) begin failures++; $display("[TB] FAIL abort_counters got=%h exp=%h", {GoodCnt, BadCnt, DropCnt}, {expGood, expBad, expDrop}); end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_reset_midframe();
        makeFrame(60);
        buildBurst(7);
        bQ = bQ[0:17];
        driveBurst(0, -1, 0);
        useBurst();
        modelBurst(2, 0);
        @(negedge clk125);
        #2;
        rst_n = 1'b0;
        expGood = 0; expBad = 0; expDrop = 0;
        #1;
        checks++;
        if ({Data_Out, Val_Out, SoF_Out, EoF_Out, Good_Out, Bad_Out, ErrCode_Out, GoodCnt, BadCnt, DropCnt} !== 65'd0) begin
            failures++;
            $display("[TB] FAIL midframe_reset_outputs got=%h exp=0", {Data_Out, Val_Out, SoF_Out, EoF_Out, Good_Out, Bad_Out, ErrCode_Out, GoodCnt, BadCnt, DropCnt});
        end
        repeat (2) @(posedge clk125);
        @(negedge clk125);
        rst_n = 1'b1;
        @(posedge clk125);
        #1;
        makeFrame(60);
        buildBurst(7);
        driveBurst(0, -1, 1);
        useBurst();
        modelBurst(0, 0);
        settle();
        checks++;
        if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL midframe_reset_events got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL midframe_reset_ev%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++;
        if ({GoodCnt, BadCnt, DropCnt} !== {expGood, expBad, expDrop}) begin failures++; $display("[TB] FAIL midframe_reset_counters got=%h exp=%h", {GoodCnt, BadCnt, DropCnt}, {expGood, expBad, expDrop}); end
        gotQ.delete(); expQ.delete();
    endtask

    task automatic test_back_to_back();
        int sizes[7] = '{60, 0, 1, 59, 1518, 45, 30};
        for (int i = 0; i < 7; i++) begin
            makeFrame(sizes[i]);
            buildBurst((i == 6) ? 8 : 7);
            driveBurst((i % 2 == 0) ? 0 : 2, (i == 5) ? 8 + 3 : -1, 1);
            useBurst();
            modelBurst(0, 0);
        end
        settle();
        checks++;
        if (gotQ.size() != expQ.size()) begin failures++; $display("[TB] FAIL back_to_back_events got=%0d exp=%0d", gotQ.size(), expQ.size()); end
        foreach (expQ[i]) if (i < gotQ.size()) begin
            checks++;
            if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL back_to_back_ev%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++;
        if ({GoodCnt, BadCnt, DropCnt} !== {expGood, expBad, expDrop}) begin failures++; $display("[TB] FAIL back_to_back_counters got=%h exp=%h", {GoodCnt, BadCnt, DropCnt}, {expGood, expBad, expDrop}); end
        gotQ.delete(); expQ.delete();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_rgmii_error_sparse();
        test_preamble_drop();
        test_abort_and_oversize();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_frame_checker.md
# rgmii_rx_frame_checker

Receive-side Ethernet frame checker on the 125 MHz domain, directly downstream of the RGMII oversampling receiver and its clock-crossing FIFO. Strips preamble/SFD, validates FCS (CRC-32), frame length and RGMII error status, and forwards the payload with the 4-byte FCS removed. A good/bad verdict pulse and an error code accompany the last byte. Frame statistics are kept in three counters.

## Interface
- MIN_LEN, 64: minimum legal frame length in bytes (DA through FCS inclusive).
- MAX_LEN, 1522: maximum legal frame length in bytes (DA through FCS inclusive).
- clk125  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Data_In  input  8  received byte; meaningful only when Val_In=1.
- Val_In  input  1  byte strobe; sparse (not every cycle).
- Err_In  input  1  RGMII receive error, qualified by Val_In.
- SoF_In  input  1  first byte of burst (first preamble byte), qualified by Val_In.
- EoF_In  input  1  last byte of burst (last FCS byte), qualified by Val_In.
- Data_Out  output  8  forwarded byte.
- Val_Out  output  1  Data_Out valid.
- SoF_Out  output  1  first forwarded byte (DA[0]).
- EoF_Out  output  1  last forwarded byte, or abort marker (Val_Out=0).
- Good_Out  output  1  pulse with EoF_Out: frame passed all checks.
- Bad_Out  output  1  pulse with EoF_Out: frame failed.
- ErrCode_Out  output  3  valid with EoF_Out: {crc_err, len_err, rgmii_err}; 3'b000 when Good_Out.
- GoodCnt  output  16  good frames, wraps.
- BadCnt  output  16  bad/aborted frames, wraps.
- DropCnt  output  16  bursts rejected in preamble, wraps.

## Operation
- Input byte accepted only when Val_In=1; SoF_In/EoF_In/Err_In ignored when Val_In=0.
- States: IDLE, PREAMBLE, PAYLOAD.
- IDLE: SoF_In byte 0x55 -> PREAMBLE (preamble count=1). SoF_In with 0xD5 -> PAYLOAD. Any other SoF byte -> DropCnt+1, stay IDLE. Non-SoF bytes ignored.
- PREAMBLE: 0x55 -> count+1; count must not exceed 7, an 8th 0x55 -> drop. 0xD5 -> PAYLOAD, CRC reg=0xFFFFFFFF, length=0, flags cleared. Other byte, Err_In=1, or EoF_In -> DropCnt+1, IDLE.
- PAYLOAD: each byte updates CRC (reflected poly 0xEDB88320, LSB first) and length (16-bit, saturates at 0xFFFF). Byte enters 4-deep shift register. When the register already holds 4 bytes, the oldest byte is emitted. SoF_Out is set on the first emitted byte of the frame. Err_In=1 sets sticky rgmii_err.
- EoF_In in PAYLOAD: the final byte is included in CRC and length.
  - crc_err = (CRC reg != 0xDEBB20E3).
  - len_err = (length < MIN_LEN) or (length > MAX_LEN).
  - If at least one byte is emitted on this cycle: EoF_Out with that byte.
  - If length ≤ 4: nothing was ever emitted; an abort marker is issued (EoF_Out=1, Val_Out=0, SoF_Out=0) with Bad_Out, len_err=1.
  - Good_Out = no error bits set, else Bad_Out. The matching counter increments. Next state IDLE; shift register cleared.
- SoF_In while in PAYLOAD (missing EoF): abort marker (EoF_Out=1, Val_Out=0, Bad_Out=1, ErrCode={crc_err=0,len_err=1,rgmii_err sticky}), BadCnt+1. The new byte is then processed as the IDLE SoF rule on the same cycle.
- SoF_In and EoF_In on the same byte: treated as SoF then EoF, so IDLE/PREAMBLE -> drop.

## Timing
- All outputs registered. Reset values: Data_Out=0, all strobes 0, ErrCode_Out=0, counters=0, state IDLE, shift register empty.
- Payload byte k is output 1 clk125 cycle after input byte k+4 is accepted. EoF_Out, Good_Out/Bad_Out and ErrCode_Out appear 1 cycle after the EoF_In byte.
- Throughput: one byte per cycle sustained. Every output strobe is a single-cycle pulse.
- No backpressure; the block never stalls the input.
- Counters update on the same cycle as the Good_Out/Bad_Out pulse, or 1 cycle after the dropped byte for DropCnt.
- rst_n asserted mid-frame: everything returns to reset values immediately, with no EoF_Out emitted. After release, the block waits for the next SoF_In.

## Test plan
- 7×0x55, 0xD5, then a 64-byte frame (60 data + correct FCS), back-to-back Val_In -> 60 Val_Out bytes matching input, SoF_Out on byte 1, EoF_Out+Good_Out on byte 60, ErrCode_Out=000, GoodCnt=1.
- Same frame with one data bit flipped -> 60 bytes out, Bad_Out, ErrCode_Out=100, BadCnt=1.
- Same frame, Val_In at 1-of-3 cycles, Err_In=1 on byte 20 -> identical data out, Bad_Out, ErrCode_Out=001.
- 3×0x55 then 0x12 -> no output, DropCnt=1; a following good frame -> Good_Out.
- SoF_In arriving after 30 payload bytes -> abort marker (EoF_Out=1, Val_Out=0, Bad_Out=1, ErrCode_Out=010), then the new frame is checked normally. A 1530-byte frame with correct FCS -> Bad_Out with ErrCode_Out=010.
- rst_n pulsed low for 2 cycles after 10 payload bytes -> all outputs 0 and counters 0, no EoF_Out; the next frame passes normally.
